wb_uart_fifo: RTL and testbench
===============================

Name: wb_uart_fifo

Overview:
Buffered, interrupt-capable UART that drops into a Wishbone slave slot of the LM32 SoC in place of the unbuffered uart0, so firmware can enable the UART interrupt line.
- Contains an 8N1 serializer and deserializer, a TX FIFO and an RX FIFO, and a programmable baud divisor.
- Provides a level interrupt driven by RX-data-available and TX-drained conditions.

Parameters:
- clk_freq, 50000000, system clock in Hz
- baud, 115200, reset baud rate; reset divisor = clk_freq/baud (integer division, 434 at defaults)
- fifo_aw, 4, log2 of each FIFO's depth (16 entries)

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- wb_adr_i  in  32  byte address; only bits [3:2] are decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_sel_i  in  4  byte selects; ignored, all accesses are treated as full-word
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- intr  out  1  level interrupt, active-high
- uart_rxd  in  1  serial input, asynchronous
- uart_txd  out  1  serial output

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - Reset values: wb_ack_o=0, wb_dat_o=0, intr=0, uart_txd=1.
  - Both FIFOs empty, IE=0, sticky flags cleared, divisor = clk_freq/baud.
  - Reset mid-byte aborts the frame immediately: txd returns to 1 and the partial RX byte is discarded.
- Wishbone handshake:
  - wb_ack_o pulses high the cycle after stb&cyc&~ack, so every access takes 2 cycles.
  - Side effects (FIFO push/pop, flag clears) occur exactly once per access, in the cycle ack is set.
- Register map (word offset by adr[3:2]):
  - 0 RXTX:
    - Read returns {24'b0, RX head} and pops the RX FIFO. Reading when empty returns 0 and does not pop.
    - Write pushes dat_i[7:0] into the TX FIFO. Writing when full drops the byte and sets sticky tx_ovf.
  - 1 STATUS (read):
    - bit0 rx_avail
    - bit1 tx_full
    - bit2 tx_idle (FIFO empty and serializer idle)
    - bit3 rx_ovr
    - bit4 frame_err
    - bit5 tx_ovf
    - bits[12:8] rx_count
    - Writing a 1 to bit3, bit4 or bit5 clears that flag.
  - 2 IE (read/write): bit0 rx_ie, bit1 tx_ie.
  - 3 DIVISOR (read/write): bits[15:0].
    - A write of 0 or 1 is stored as 2.
    - A new value takes effect at the next bit boundary.
- intr = (rx_ie & rx_avail) | (tx_ie & tx_idle), registered (1-cycle delay).
- RX path:
  - uart_rxd passes through a 2-flop synchronizer (both flops reset to 1).
  - FSM IDLE → START on a synchronized falling edge.
  - START waits divisor/2 cycles, then resamples: 1 → back to IDLE (glitch), 0 → DATA.
  - DATA samples 8 bits LSB-first, one every divisor cycles, then goes to STOP.
  - STOP samples after divisor cycles:
    - Sample 0 → discard byte, set frame_err.
    - Sample 1 with FIFO full → discard byte, set rx_ovr.
    - Otherwise push the byte.
  - STOP → IDLE.
- Simultaneous RX push and CPU pop in the same cycle: both happen and the count is unchanged. With the FIFO full, the pop frees space first, so the push succeeds.
- TX path:
  - FSM IDLE: when the FIFO is non-empty, pop → START, driving txd=0 for divisor cycles.
  - DATA: 8 bits LSB-first, divisor cycles each.
  - STOP: txd=1 for divisor cycles, then → IDLE.
  - Back-to-back bytes have no gap: frame period is exactly 10*divisor cycles.
- FIFOs:
  - Pointers are fifo_aw+1 bits wide with wrap-around.
  - Full = MSBs differ and lower bits equal; empty = pointers equal.
  - Count = wr-rd, modulo 2^(fifo_aw+1).

Decomposition:
- Shared package holds:
  - register offsets RXTX=0, STATUS=1, IE=2, DIV=3
  - STATUS bit indices
  - RX/TX state encodings IDLE, START, DATA, STOP
- One sub-module, sync_fifo (parameters width, aw), instantiated twice.
  - Interface: push/pop/din/dout/full/empty/count.
  - dout is first-word-fall-through.

Test Plan:
- Reset, then read all four registers → RXTX=0, STATUS=0x04, IE=0, DIV=434; txd=1; intr=0.
- DIV=4, write 0x55 to RXTX → txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high. tx_idle=1 exactly 40 cycles after the pop.
- DIV=4, drive an 8N1 frame of 0xA3 on rxd → STATUS bit0=1, rx_count=1; RXTX read returns 0xA3; count returns to 0; a second read returns 0.
- DIV=4, IE=1, send 17 RX frames without reading:
  - intr rises after the first frame.
  - After the 17th frame: rx_count=16, rx_ovr=1.
  - 16 reads return the bytes in order; intr drops after the last read.
- Write 17 bytes with DIV=434 → tx_full=1 after 17 writes (16 in FIFO plus 1 in flight). An 18th write sets tx_ovf. Writing STATUS=0x20 clears tx_ovf.
- 0-bit stop (rxd held low through the stop sample) → frame_err=1 and no push. A 1-cycle low glitch on idle rxd → no state change.

Source files
------------

// File: rtl/wb_uart_fifo_pkg.sv
// Shared definitions for wb_uart_fifo: register offsets, STATUS bit positions,
// serializer/deserializer state encoding and the divisor clamp helper.
package wb_uart_fifo_pkg;

  localparam logic [1:0] REG_RXTX   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IE     = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVR     = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_TX_OVF     = 5;
  localparam int ST_RX_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Divisors below 2 would leave no room for the half-bit start sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/wb_uart_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one wrap bit so
// full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int width = 8,
  parameter int aw    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] din_i,
  output logic [width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [aw:0]      count_o
);

  localparam logic [aw:0] PTR_ONE = {{aw{1'b0}}, 1'b1};

  logic [width-1:0] mem_q [2**aw];
  logic [aw:0]      wr_ptr_q, wr_ptr_d;
  logic [aw:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                   (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[aw-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[aw-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone slave UART: 8N1 serializer/deserializer, TX and RX FIFOs,
// programmable baud divisor and a registered level interrupt.
module wb_uart_fifo
  import wb_uart_fifo_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200,
  parameter int fifo_aw  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int          CW        = fifo_aw + 1;
  localparam logic [15:0] DIV_RESET = clamp_div(16'(clk_freq / baud));

  logic        ack_q;
  logic [31:0] dat_q;
  logic [1:0]  ie_q;
  logic [15:0] div_q;
  logic        rx_ovr_q, frame_err_q, tx_ovf_q, intr_q;

  logic        acc, wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_push_req, tx_idle, tx_ovf_set;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, frame_err_set;
  logic [7:0]    rx_dout;
  logic [CW-1:0] rx_count;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shr_q, tx_shr_d;
  logic        txd_q, txd_d, tx_tick;

  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shr_q, rx_shr_d;
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q, rx_tick;

  assign acc     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign reg_sel = wb_adr_i[3:2];
  assign wr      = acc & wb_we_i;
  assign rd      = acc & ~wb_we_i;

  assign rx_pop      = rd & (reg_sel == REG_RXTX) & ~rx_empty;
  assign tx_push_req = wr & (reg_sel == REG_RXTX);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;
  assign tx_idle     = tx_empty & (tx_state_q == IDLE);

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_RXTX:   rdata[7:0] = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: begin
        rdata[ST_RX_AVAIL]            = ~rx_empty;
        rdata[ST_TX_FULL]             = tx_full;
        rdata[ST_TX_IDLE]             = tx_idle;
        rdata[ST_RX_OVR]              = rx_ovr_q;
        rdata[ST_FRAME_ERR]           = frame_err_q;
        rdata[ST_TX_OVF]              = tx_ovf_q;
        rdata[ST_RX_CNT_LSB +: CW]    = rx_count;
      end
      REG_IE:     rdata[1:0]  = ie_q;
      REG_DIV:    rdata[15:0] = div_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ie_q        <= '0;
      div_q       <= DIV_RESET;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= wb_we_i ? 32'h0 : rdata;
      if (wr && reg_sel == REG_IE)  ie_q  <= wb_dat_i[1:0];
      if (wr && reg_sel == REG_DIV) div_q <= clamp_div(wb_dat_i[15:0]);
      if (wr && reg_sel == REG_STATUS) begin
        if (wb_dat_i[ST_RX_OVR])    rx_ovr_q    <= 1'b0;
        if (wb_dat_i[ST_FRAME_ERR]) frame_err_q <= 1'b0;
        if (wb_dat_i[ST_TX_OVF])    tx_ovf_q    <= 1'b0;
      end
      // A new event in the same cycle as a clear keeps the flag set.
      if (rx_ovr_set)    rx_ovr_q    <= 1'b1;
      if (frame_err_set) frame_err_q <= 1'b1;
      if (tx_ovf_set)    tx_ovf_q    <= 1'b1;
      intr_q <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_idle);
    end
  end

  // Transmitter: the bit timer reloads from div_q at every bit boundary.
  assign tx_tick = (tx_cnt_q == '0);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shr_d   = tx_shr_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shr_d   = tx_dout;
          txd_d      = 1'b0;
          tx_cnt_d   = div_q - 16'd1;
          tx_state_d = START;
        end
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_bit_d   = '0;
        txd_d      = tx_shr_q[0];
        tx_cnt_d   = div_q - 16'd1;
      end
      DATA: if (tx_tick) begin
        tx_cnt_d = div_q - 16'd1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_shr_d = tx_shr_q >> 1;
          txd_d    = tx_shr_q[1];
        end
      end
      STOP: if (tx_tick) begin
        tx_cnt_d = div_q - 16'd1;
        // Chain straight into the next start bit so frames have no gap.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shr_d   = tx_dout;
          txd_d      = 1'b0;
          tx_state_d = START;
        end else begin
          tx_state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shr_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shr_q   <= tx_shr_d;
      txd_q      <= txd_d;
    end
  end

  assign rx_tick = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_tick ? rx_cnt_q : rx_cnt_q - 16'd1;
    rx_bit_d      = rx_bit_q;
    rx_shr_d      = rx_shr_q;
    rx_push       = 1'b0;
    rx_ovr_set    = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state_q)
      IDLE: if (rxd_prev_q && !rxd_sync_q) begin
        rx_state_d = START;
        rx_cnt_d   = (div_q >> 1) - 16'd1;
      end
      START: if (rx_tick) begin
        if (rxd_sync_q) begin
          rx_state_d = IDLE;
        end else begin
          rx_state_d = DATA;
          rx_bit_d   = '0;
          rx_cnt_d   = div_q - 16'd1;
        end
      end
      DATA: if (rx_tick) begin
        rx_shr_d = {rxd_sync_q, rx_shr_q[7:1]};
        rx_cnt_d = div_q - 16'd1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      STOP: if (rx_tick) begin
        rx_state_d = IDLE;
        if (!rxd_sync_q)              frame_err_set = 1'b1;
        else if (rx_full && !rx_pop)  rx_ovr_set    = 1'b1;
        else                          rx_push       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shr_q   <= '0;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shr_q   <= rx_shr_d;
    end
  end

  sync_fifo #(.width(8), .aw(fifo_aw)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (wb_dat_i[7:0]),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  sync_fifo #(.width(8), .aw(fifo_aw)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (rx_shr_q),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;
  assign uart_txd = txd_q;

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:16], tx_count};

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Self-checking bench for wb_uart_fifo: directed sequence with random payloads,
// checked against a queue-based model of the register map and serial framing.
module tb_wb_uart_fifo;

  localparam int DIV_EXP = 50000000 / 115200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic        intr, uart_rxd, uart_txd;

  wb_uart_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_ack_o (wb_ack_o),
    .intr     (intr),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_ovr, m_ferr, m_tovf;

  // Serial capture of txd/intr, one sample per falling clock edge
  bit   cap_en = 1'b0;
  int   cap_n  = 0;
  logic cap_txd  [512];
  logic cap_intr [512];

  always @(negedge clk) begin
    if (!cap_en) cap_n = 0;
    else if (cap_n < 512) begin
      cap_txd[cap_n]  = uart_txd;
      cap_intr[cap_n] = intr;
      cap_n = cap_n + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_acc(input logic [1:0] r, input bit we, input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge clk);
    wb_adr_i = {28'h0, r, 2'b00};
    wb_dat_i = d;
    wb_we_i  = we;
    wb_sel_i = 4'($urandom());
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb_ack_o !== 1'b1 && n < 8);
    q = wb_dat_o;
    chk("wb_ack", 64'(wb_ack_o), 64'd1);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    wb_acc(r, 1'b1, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] q;
    wb_acc(r, 1'b0, 32'h0, q);
    chk(tag, 64'(q), 64'(exp));
  endtask

  function automatic logic [31:0] st_exp(input bit tidle, input bit tfull);
    logic [31:0] v;
    v = '0;
    v[0]    = (rxq.size() > 0);
    v[1]    = tfull;
    v[2]    = tidle;
    v[3]    = m_ovr;
    v[4]    = m_ferr;
    v[5]    = m_tovf;
    v[12:8] = 5'(rxq.size());
    return v;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Drives one 8N1 frame on rxd and updates the model; stop_ok=0 holds the line low.
  task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int div);
    for (int k = 0; k < 10; k++) begin
      uart_rxd = (k == 9) ? stop_ok : frame_bit(b, k);
      repeat (div) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    if (!stop_ok) m_ferr = 1'b1;
    else if (rxq.size() == 16) m_ovr = 1'b1;
    else rxq.push_back(b);
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] exp;
    exp = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    rd_chk(tag, 2'd0, exp);
  endtask

  task automatic restart_capture();
    cap_en = 1'b0;
    repeat (2) @(negedge clk);
    cap_en = 1'b1;
  endtask

  task automatic check_tx(input string tag, output int s);
    logic [3:0] obs;
    s = -1;
    for (int i = 0; i < cap_n; i++)
      if (cap_txd[i] === 1'b0) begin
        s = i;
        break;
      end
    chk({tag, "_start"}, 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    for (int f = 0; f < txq.size(); f++)
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < 4; j++) obs[j] = cap_txd[s + 40*f + 4*k + j];
        chk($sformatf("%s_f%0d_b%0d", tag, f, k), 64'(obs), 64'({4{frame_bit(txq[f], k)}}));
      end
    chk({tag, "_tail"}, 64'(cap_txd[s + 40*txq.size()]), 64'd1);
  endtask

  initial begin
    int s, n;
    logic [7:0] b;
    logic [31:0] q;

    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    uart_rxd = 1'b1;
    m_ovr = 0; m_ferr = 0; m_tovf = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  64'(wb_ack_o), 64'd0);
    chk("rst_dat",  64'(wb_dat_o), 64'd0);
    chk("rst_intr", 64'(intr),     64'd0);
    chk("rst_txd",  64'(uart_txd), 64'd1);
    rst = 1'b0;

    rd_chk("rst_rxtx",   2'd0, 32'h0);
    rd_chk("rst_status", 2'd1, st_exp(1, 0));
    rd_chk("rst_ie",     2'd2, 32'h0);
    rd_chk("rst_div",    2'd3, 32'(DIV_EXP));
    chk("rst_txd_idle", 64'(uart_txd), 64'd1);

    wb_wr(2'd3, 32'h1);
    rd_chk("div_clamp1", 2'd3, 32'd2);
    wb_wr(2'd3, 32'h4);
    rd_chk("div4", 2'd3, 32'd4);

    // Single TX frame of 0x55; tx_ie lets intr expose the tx_idle instant
    wb_wr(2'd2, 32'h2);
    rd_chk("ie_rb", 2'd2, 32'h2);
    restart_capture();
    txq = {8'h55};
    wb_wr(2'd0, 32'h55);
    repeat (70) @(negedge clk);
    check_tx("tx55", s);
    chk("tx_idle_at40", 64'(cap_intr[s + 40]), 64'd0);
    chk("tx_idle_at41", 64'(cap_intr[s + 41]), 64'd1);

    // Two random bytes back to back: 80 cycles with no gap
    restart_capture();
    txq = {8'($urandom()), 8'($urandom())};
    wb_wr(2'd0, {24'h0, txq[0]});
    wb_wr(2'd0, {24'h0, txq[1]});
    repeat (100) @(negedge clk);
    check_tx("txb2b", s);
    cap_en = 1'b0;

    // RX single frame
    wb_wr(2'd2, 32'h1);
    repeat (3) @(negedge clk);
    chk("intr_rx_empty", 64'(intr), 64'd0);
    send_rx(8'hA3, 1'b1, 4);
    rd_chk("rx1_status", 2'd1, st_exp(1, 0));
    chk("intr_rx1", 64'(intr), 64'd1);
    rx_read("rx1_data");
    rd_chk("rx1_status_after", 2'd1, st_exp(1, 0));
    rx_read("rx1_empty_read");

    // 17 frames without reading: overrun on the last
    for (int i = 0; i < 17; i++) begin
      send_rx(8'($urandom()), 1'b1, 4);
      if (i == 0) chk("intr_first_frame", 64'(intr), 64'd1);
    end
    rd_chk("rx17_status", 2'd1, st_exp(1, 0));
    for (int i = 0; i < 16; i++) rx_read($sformatf("rx17_data%0d", i));
    repeat (3) @(negedge clk);
    chk("intr_drained", 64'(intr), 64'd0);
    wb_wr(2'd1, 32'h08);
    m_ovr = 1'b0;
    rd_chk("ovr_clear", 2'd1, st_exp(1, 0));

    // Framing error, then an idle-line glitch, then a clean frame
    send_rx(8'($urandom()), 1'b0, 4);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("ferr_status", 2'd1, st_exp(1, 0));
    wb_wr(2'd1, 32'h10);
    m_ferr = 1'b0;
    rd_chk("ferr_clear", 2'd1, st_exp(1, 0));
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_status", 2'd1, st_exp(1, 0));
    b = 8'($urandom());
    send_rx(b, 1'b1, 4);
    rx_read("post_glitch_data");

    // TX FIFO full / overflow at the slow reset-rate divisor
    wb_wr(2'd3, 32'(DIV_EXP));
    for (int i = 0; i < 17; i++) wb_wr(2'd0, 32'($urandom_range(0, 255)));
    rd_chk("tx_full", 2'd1, st_exp(0, 1));
    wb_wr(2'd0, 32'h5A);
    m_tovf = 1'b1;
    rd_chk("tx_ovf", 2'd1, st_exp(0, 1));
    wb_wr(2'd1, 32'h20);
    m_tovf = 1'b0;
    rd_chk("tx_ovf_clear", 2'd1, st_exp(0, 1));
    wb_wr(2'd3, 32'h0);
    rd_chk("div_clamp0", 2'd3, 32'd2);
    n = 0;
    do begin
      wb_acc(2'd1, 1'b0, 32'h0, q);
      n++;
    end while (q[2] !== 1'b1 && n < 1000);
    chk("tx_drain_status", 64'(q), 64'(st_exp(1, 0)));
    chk("tx_drain_txd", 64'(uart_txd), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
